// File: rtl/cnn_layer_accel_prefetch_sequencer.sv
// ============================================================================
// Module   : cnn_layer_accel_prefetch_sequencer
// Purpose  : Read-side sequencer for the per-row prefetch buffer. Walks the
//            expanded (padded and/or upsampled) input image in row-major
//            order, waits for each fetched row, streams it column by column,
//            replays upsampled rows from the same buffer contents and
//            acknowledges job completion.
// Ports    : rd_clk, rst            - clock, synchronous active-high reset
//            start                  - single-cycle job start (IDLE only)
//            padding, upsample      - job config, latched on accepted start
//            expd_num_input_cols    - last column index (inclusive)
//            expd_num_input_rows    - last row index (inclusive)
//            row_ready              - buffer holds the next fetched row
//            stall                  - downstream back-pressure
//            rd_en                  - buffer read strobe (combinational)
//            input_col, input_row   - current expanded coordinates
//            rst_addr               - rewinds the buffer read address
//            row_done               - pulse after each row's last column
//            job_complete_ack       - pulse at job end
//            busy                   - sequencer not idle
// Config   : `PREFETCH_SEQ_UPSAMPLE_EN enables the upsample replay path.
//            Without it, upsample is ignored and rst_addr is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_layer_accel_prefetch_sequencer #(
    parameter int C_ADDR_WIDTH = 10
) (
    input  logic                    rd_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    padding,
    input  logic                    upsample,
    input  logic [C_ADDR_WIDTH-1:0] expd_num_input_cols,
    input  logic [C_ADDR_WIDTH-1:0] expd_num_input_rows,
    input  logic                    row_ready,
    input  logic                    stall,
    output logic                    rd_en,
    output logic [C_ADDR_WIDTH-1:0] input_col,
    output logic [C_ADDR_WIDTH-1:0] input_row,
    output logic                    rst_addr,
    output logic                    row_done,
    output logic                    job_complete_ack,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ROW = 3'd1,
        S_STREAM   = 3'd2,
        S_ROW_END  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [C_ADDR_WIDTH-1:0] C_ONE  = {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_ADDR_WIDTH-1:0] C_ZERO = '0;

    state_t                  state_q;
    logic [C_ADDR_WIDTH-1:0] col_q;
    logic [C_ADDR_WIDTH-1:0] row_q;
    logic [C_ADDR_WIDTH-1:0] last_col_q;
    logic [C_ADDR_WIDTH-1:0] last_row_q;
    logic                    pad_q;
    logic                    row_done_q;
    logic                    ack_q;
    logic                    busy_q;

    logic w_up;
    logic w_pad_row;
    logic w_last_col;
    logic w_last_row;
    logic w_replay;

`ifdef PREFETCH_SEQ_UPSAMPLE_EN
    logic up_q;
    logic rst_addr_q;
    assign w_up     = up_q;
    assign rst_addr = rst_addr_q;
`else
    // upsample has no effect in this build; keep the input visibly consumed.
    logic w_unused_upsample;
    assign w_unused_upsample = upsample;
    assign w_up              = 1'b0;
    assign rst_addr          = 1'b0;
`endif

    assign w_last_col = (col_q == last_col_q);
    assign w_last_row = (row_q == last_row_q);

    // Pad rows are synthesised by the buffer, so they never wait for a fetch.
    assign w_pad_row = pad_q && !w_up && ((row_q == C_ZERO) || w_last_row);

    // An even row in upsample mode is followed by its replay, which reuses the
    // buffer contents already present instead of fetching a new row.
    assign w_replay = w_up && !row_q[0] && !w_last_row;

    // Combinational so the strobe lines up with the registered address.
    assign rd_en = (state_q == S_STREAM) && !stall;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            last_col_q <= '0;
            last_row_q <= '0;
            pad_q      <= 1'b0;
            row_done_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PREFETCH_SEQ_UPSAMPLE_EN
            up_q       <= 1'b0;
            rst_addr_q <= 1'b0;
`endif
        end else begin
            row_done_q <= 1'b0;
            ack_q      <= 1'b0;
`ifdef PREFETCH_SEQ_UPSAMPLE_EN
            rst_addr_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pad_q      <= padding;
                        last_col_q <= expd_num_input_cols;
                        last_row_q <= expd_num_input_rows;
                        col_q      <= '0;
                        row_q      <= '0;
                        state_q    <= S_WAIT_ROW;
                        busy_q     <= 1'b1;
`ifdef PREFETCH_SEQ_UPSAMPLE_EN
                        up_q       <= upsample;
`endif
                    end
                end

                S_WAIT_ROW: begin
                    if (row_ready || w_pad_row) begin
                        state_q <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (!stall) begin
                        if (w_last_col) begin
                            // Row-end pulses are registered, so they are set
                            // on entry to make them coincide with ROW_END.
                            state_q    <= S_ROW_END;
                            row_done_q <= 1'b1;
`ifdef PREFETCH_SEQ_UPSAMPLE_EN
                            rst_addr_q <= w_replay;
`endif
                        end else begin
                            col_q <= col_q + C_ONE;
                        end
                    end
                end

                S_ROW_END: begin
                    if (w_last_row) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                    end else begin
                        row_q   <= row_q + C_ONE;
                        col_q   <= '0;
                        state_q <= w_replay ? S_STREAM : S_WAIT_ROW;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign input_col        = col_q;
    assign input_row        = row_q;
    assign row_done         = row_done_q;
    assign job_complete_ack = ack_q;
    assign busy             = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_prefetch_sequencer.sv
// ============================================================================
// Module   : tb_cnn_layer_accel_prefetch_sequencer
// Purpose  : Self-checking bench for cnn_layer_accel_prefetch_sequencer.
//            Directed jobs push their hand-computed read/row-end/rewind/ack
//            events (with cycle offsets from start) into queues; a monitor
//            pops and compares whenever the DUT presents one of them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_layer_accel_prefetch_sequencer;

    localparam int C_W = 10;

    logic           rd_clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           padding = 1'b0;
    logic           upsample = 1'b0;
    logic [C_W-1:0] expd_num_input_cols = '0;
    logic [C_W-1:0] expd_num_input_rows = '0;
    logic           row_ready = 1'b1;
    logic           stall = 1'b0;
    logic           rd_en;
    logic [C_W-1:0] input_col;
    logic [C_W-1:0] input_row;
    logic           rst_addr;
    logic           row_done;
    logic           job_complete_ack;
    logic           busy;

    cnn_layer_accel_prefetch_sequencer #(.C_ADDR_WIDTH(C_W)) dut (
        .rd_clk              (rd_clk),
        .rst                 (rst),
        .start               (start),
        .padding             (padding),
        .upsample            (upsample),
        .expd_num_input_cols (expd_num_input_cols),
        .expd_num_input_rows (expd_num_input_rows),
        .row_ready           (row_ready),
        .stall               (stall),
        .rd_en               (rd_en),
        .input_col           (input_col),
        .input_row           (input_row),
        .rst_addr            (rst_addr),
        .row_done            (row_done),
        .job_complete_ack    (job_complete_ack),
        .busy                (busy)
    );

    always #5 rd_clk = ~rd_clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    typedef struct {
        int row;
        int col;
        int cyc;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_done[$];
    ev_t q_rst[$];
    ev_t q_ack[$];

    int    n_total = 0;
    int    n_bad   = 0;
    string tname   = "reset";

    // ---------------- expectation helpers ----------------
    task automatic push_row(input int row, input int last_col, input int first_cyc);
        for (int c = 0; c <= last_col; c++) begin
            q_rd.push_back('{row: row, col: c, cyc: first_cyc + c});
        end
        q_done.push_back('{row: row, col: last_col, cyc: first_cyc + last_col + 1});
    endtask

    task automatic push_rst(input int row, input int at_cyc);
        q_rst.push_back('{row: row, col: 0, cyc: at_cyc});
    endtask

    task automatic push_ack(input int at_cyc);
        q_ack.push_back('{row: 0, col: 0, cyc: at_cyc});
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0d want %0d", tname, nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    ev_t e;
    task automatic cmp_ev(input string nm, input ev_t x, input bit has_rc);
        int rel;
        rel = cyc - t0;
        n_total++;
        if ((has_rc && (x.row != int'(input_row) || x.col != int'(input_col))) || x.cyc != rel) begin
            n_bad++;
            $display("FAIL %s/%s: got row=%0d col=%0d cyc=%0d want row=%0d col=%0d cyc=%0d",
                     tname, nm, input_row, input_col, rel, x.row, x.col, x.cyc);
        end
    endtask

    task automatic extra_ev(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s/%s: got unexpected event at row=%0d col=%0d cyc=%0d want none",
                 tname, nm, input_row, input_col, cyc - t0);
    endtask

    always @(negedge rd_clk) begin
        if (rd_en) begin
            if (q_rd.size() == 0) extra_ev("rd_en");
            else begin e = q_rd.pop_front(); cmp_ev("rd_en", e, 1'b1); end
        end
        if (row_done) begin
            if (q_done.size() == 0) extra_ev("row_done");
            else begin e = q_done.pop_front(); cmp_ev("row_done", e, 1'b1); end
        end
        if (rst_addr) begin
            if (q_rst.size() == 0) extra_ev("rst_addr");
            else begin
                e = q_rst.pop_front();
                e.col = int'(input_col);
                cmp_ev("rst_addr", e, 1'b1);
            end
        end
        if (job_complete_ack) begin
            if (q_ack.size() == 0) extra_ev("ack");
            else begin e = q_ack.pop_front(); cmp_ev("ack", e, 1'b0); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input bit pad, input bit up, input int cols, input int rows);
        @(posedge rd_clk); #1;
        start               = 1'b1;
        padding             = pad;
        upsample            = up;
        expd_num_input_cols = C_W'(cols);
        expd_num_input_rows = C_W'(rows);
        t0                  = cyc;
        @(posedge rd_clk); #1;
        start = 1'b0;
    endtask

    task automatic goto_cycle(input int k);
        while ((cyc - t0) < k) begin
            @(posedge rd_clk); #1;
        end
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge rd_clk);
            n++;
        end
        chk("idle_timeout", int'(busy === 1'b0), 1);
        repeat (4) @(negedge rd_clk);
        chk("rd_left", q_rd.size(), 0);
        chk("done_left", q_done.size(), 0);
        chk("rst_left", q_rst.size(), 0);
        chk("ack_left", q_ack.size(), 0);
    endtask

    task automatic chk_all_zero();
        chk("rd_en", int'(rd_en), 0);
        chk("input_col", int'(input_col), 0);
        chk("input_row", int'(input_row), 0);
        chk("rst_addr", int'(rst_addr), 0);
        chk("row_done", int'(row_done), 0);
        chk("ack", int'(job_complete_ack), 0);
        chk("busy", int'(busy), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk_all_zero();
        @(posedge rd_clk); #1;
        rst = 1'b0;

        // Basic: two 4-column rows, data always ready.
        tname = "basic";
        push_row(0, 3, 2);
        push_row(1, 3, 8);
        push_ack(13);
        start_job(1'b0, 1'b0, 3, 1);
        finish_job();

        // Padding: first/last rows stream immediately, middle rows wait.
        tname = "padding";
        row_ready = 1'b0;
        push_row(0, 2, 2);
        push_row(1, 2, 11);
        push_row(2, 2, 21);
        push_row(3, 2, 26);
        push_ack(30);
        start_job(1'b1, 1'b0, 2, 3);
        goto_cycle(10); row_ready = 1'b1;
        goto_cycle(11); row_ready = 1'b0;
        goto_cycle(20); row_ready = 1'b1;
        goto_cycle(21); row_ready = 1'b0;
        finish_job();
        row_ready = 1'b1;

        // Upsample: odd rows replay the even row's buffer contents.
        tname = "upsample";
`ifdef PREFETCH_SEQ_UPSAMPLE_EN
        push_row(0, 1, 2);
        push_rst(0, 4);
        push_row(1, 1, 5);
        push_row(2, 1, 9);
        push_rst(2, 11);
        push_row(3, 1, 12);
        push_ack(15);
`else
        for (int r = 0; r < 4; r++) push_row(r, 1, 2 + 4 * r);
        push_ack(17);
`endif
        start_job(1'b0, 1'b1, 1, 3);
        finish_job();

        // Stall on column 2 for three cycles.
        tname = "stall";
        q_rd.push_back('{row: 0, col: 0, cyc: 2});
        q_rd.push_back('{row: 0, col: 1, cyc: 3});
        q_rd.push_back('{row: 0, col: 2, cyc: 7});
        q_rd.push_back('{row: 0, col: 3, cyc: 8});
        q_rd.push_back('{row: 0, col: 4, cyc: 9});
        q_done.push_back('{row: 0, col: 4, cyc: 10});
        push_ack(11);
        start_job(1'b0, 1'b0, 4, 0);
        goto_cycle(4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            chk("stall_rd_en", int'(rd_en), 0);
            chk("stall_col", int'(input_col), 2);
            @(posedge rd_clk); #1;
        end
        stall = 1'b0;
        finish_job();

        // Reset mid-row at column 1.
        tname = "midreset";
        q_rd.push_back('{row: 0, col: 0, cyc: 2});
        q_rd.push_back('{row: 0, col: 1, cyc: 3});
        start_job(1'b0, 1'b0, 3, 1);
        goto_cycle(3); rst = 1'b1;
        goto_cycle(4); rst = 1'b0;
        @(negedge rd_clk);
        chk_all_zero();
        finish_job();

        // Start while busy must not disturb the running job.
        tname = "ignored_start";
        push_row(0, 1, 2);
        push_row(1, 1, 6);
        push_ack(9);
        start_job(1'b0, 1'b0, 1, 1);
        goto_cycle(3);
        start               = 1'b1;
        padding             = 1'b1;
        expd_num_input_cols = C_W'(3);
        expd_num_input_rows = C_W'(3);
        goto_cycle(4);
        start = 1'b0;
        finish_job();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
